// File: rtl/norflash_pkg.sv
// Shared types and defaults for the NOR flash read controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package norflash_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    localparam int RST_CYCLES_DEF  = 4;
    localparam int WAIT_CYCLES_DEF = 3;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        SETUP,
        READ,
        END
    } state_t;

endpackage

// File: rtl/norflash_if.sv
// Parallel NOR flash pin bundle; master is the controller, slave is the flash.
// Latency: n/a (wires only).
// Backpressure: n/a.
interface norflash_if;
    import norflash_pkg::*;

    logic [ADDR_W-1:0] flash_addr;
    logic              flash_ce_n;
    logic              flash_oe_n;
    logic              flash_we_n;
    logic              flash_rst_n;
    // The controller only ever samples the data bus, so it is never driven from the master side.
    logic [DATA_W-1:0] flash_data;

    modport master (
        output flash_addr, flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n,
        input  flash_data
    );

    modport slave (
        input  flash_addr, flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n,
        output flash_data
    );

endinterface

// File: rtl/key_sync_edge.sv
// Synchronises the push-button and flags each falling edge as a one-cycle press.
// Latency: press rises SYNC_STAGES clocks after k1_n falls.
// Backpressure: none; presses not consumed are simply lost.
module key_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign press = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/norflash_ctrl.sv
// Key-triggered NOR flash reader: one async read per press, then address increments.
// Latency: oe_n low 2 clocks after press; WAIT_CYCLES+2 clocks per read.
// Backpressure: presses arriving while a read is in flight are dropped.
module norflash_ctrl
    import norflash_pkg::*;
#(
    parameter int RST_CYCLES  = RST_CYCLES_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              k1_n,
    norflash_if.master        flash,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic              press;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              ce_n_q, oe_n_q, frst_n_q;
    logic              sample;

    key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (k1_n),
        .press     (press)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RST_HOLD: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE:  if (press) state_d = SETUP;
            SETUP: begin
                state_d = READ;
                cnt_d   = '0;
            end
            READ: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                    state_d = END;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            END:     state_d = IDLE;
            default: state_d = RST_HOLD;
        endcase
    end

    assign sample = (state_q == READ) && (state_d == END);

    // Strobes are registered from the next state so every pin comes straight off a flop.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= RST_HOLD;
            cnt_q    <= '0;
            addr_q   <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            frst_n_q <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ce_n_q   <= !((state_d == SETUP) || (state_d == READ));
            oe_n_q   <= (state_d != READ);
            rd_valid <= sample;
            if (state_q == RST_HOLD && state_d == IDLE) frst_n_q <= 1'b1;
            if (sample) rd_data <= flash.flash_data;
            if (state_q == END) addr_q <= addr_q + 1'b1;
        end
    end

    assign flash.flash_addr  = addr_q;
    assign flash.flash_ce_n  = ce_n_q;
    assign flash.flash_oe_n  = oe_n_q;
    assign flash.flash_we_n  = 1'b1;
    assign flash.flash_rst_n = frst_n_q;

endmodule

// File: tb/tb_norflash_ctrl.sv
// Bench for norflash_ctrl: phase-offset reference model compared every cycle plus literal checks.
module tb_norflash_ctrl;
    import norflash_pkg::*;

    localparam int RC = 4;
    localparam int WC = 3;
    localparam int SS = 2;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       k1_n      = 1'b1;
    logic [7:0] fdata     = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;

    norflash_if bus ();
    assign bus.flash_data = fdata;

    norflash_ctrl #(
        .RST_CYCLES  (RC),
        .WAIT_CYCLES (WC),
        .SYNC_STAGES (SS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .k1_n      (k1_n),
        .flash     (bus),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: r = clocks since reset release, ph = clocks since the accepted press
    // (SETUP at 1, READ at 2..WC+1, END at WC+2), kh = k1_n as seen at recent edges.
    int         r       = 0;
    int         ph      = -1;
    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic [7:0] kh      = 8'hFF;
    logic       press_prev, idle_prev;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r = 0; ph = -1; m_addr = 8'h00; m_data = 8'h00; m_valid = 1'b0; kh = 8'hFF;
        end else begin
            r++;
            kh = {kh[6:0], k1_n};
            press_prev = kh[SS+1] && !kh[SS];
            idle_prev  = (r - 1 >= RC) && (ph < 0);
            m_valid = 1'b0;
            if (ph == WC + 2) begin
                ph = -1;
                m_addr = m_addr + 8'h01;
            end else if (ph >= 0) begin
                ph++;
                if (ph == WC + 2) begin
                    m_valid = 1'b1;
                    m_data  = fdata;
                end
            end else if (press_prev && idle_prev) begin
                ph = 1;
            end
        end
    end

    int ce_low_cnt = 0;
    int oe_low_cnt = 0;
    int valid_cnt  = 0;

    always @(negedge sys_clk) begin
        chk("ce_n",    bus.flash_ce_n,  !(ph >= 1 && ph <= WC + 1));
        chk("oe_n",    bus.flash_oe_n,  !(ph >= 2 && ph <= WC + 1));
        chk("we_n",    bus.flash_we_n,  1'b1);
        chk("rst_n",   bus.flash_rst_n, r >= RC);
        chk("addr",    bus.flash_addr,  m_addr);
        chk("rd_vld",  rd_valid,        m_valid);
        chk("rd_data", rd_data,         m_data);
        if (bus.flash_ce_n == 1'b0) ce_low_cnt++;
        if (bus.flash_oe_n == 1'b0) oe_low_cnt++;
        if (rd_valid == 1'b1) valid_cnt++;
    end

    task automatic do_press(input logic [7:0] d, input int hold, input bit glitch);
        @(negedge sys_clk);
        fdata = d;
        k1_n  = 1'b0;
        if (glitch) begin
            @(negedge sys_clk) k1_n = 1'b1;
            @(negedge sys_clk) k1_n = 1'b0;
        end
        repeat (hold) @(negedge sys_clk);
        k1_n = 1'b1;
        repeat (WC + 6) @(negedge sys_clk);
    endtask

    initial begin
        int n;
        logic [7:0] seq [3];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_ce_n",  bus.flash_ce_n,  1'b1);
        chk("rst_oe_n",  bus.flash_oe_n,  1'b1);
        chk("rst_we_n",  bus.flash_we_n,  1'b1);
        chk("rst_frst",  bus.flash_rst_n, 1'b0);
        chk("rst_addr",  bus.flash_addr,  8'h00);
        chk("rst_rdvld", rd_valid,        1'b0);

        // Release reset with the key already going down: that press falls inside the hold window.
        @(negedge sys_clk);
        sys_rst_n  = 1'b1;
        k1_n       = 1'b0;
        ce_low_cnt = 0;
        repeat (3) @(posedge sys_clk);
        #1 chk("frst_at3", bus.flash_rst_n, 1'b0);
        @(posedge sys_clk);
        #1 chk("frst_at4", bus.flash_rst_n, 1'b1);
        repeat (15) @(negedge sys_clk);
        chk("hold_press_ce", ce_low_cnt, 0);
        k1_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        ce_low_cnt = 0; oe_low_cnt = 0; valid_cnt = 0;
        do_press(8'hCC, 3, 1'b0);
        chk("single_data",  rd_data,        8'hCC);
        chk("single_addr",  bus.flash_addr, 8'h01);
        chk("single_vld_n", valid_cnt,      1);
        chk("single_ce_lo", ce_low_cnt,     WC + 1);
        chk("single_oe_lo", oe_low_cnt,     WC);

        for (int i = 0; i < 3; i++) begin
            do_press(seq[i], 2, 1'b0);
            chk("seq_data", rd_data,        seq[i]);
            chk("seq_addr", bus.flash_addr, 8'(i + 2));
        end

        valid_cnt = 0;
        do_press(8'h5A, 2, 1'b1);
        chk("busy_vld_n", valid_cnt,      1);
        chk("busy_addr",  bus.flash_addr, 8'h05);
        chk("busy_data",  rd_data,        8'h5A);

        for (int i = 0; i < 250; i++) begin
            do_press(8'($urandom), $urandom_range(1, 4), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        end
        chk("pre_wrap_addr", bus.flash_addr, 8'hFF);
        do_press(8'hA7, 2, 1'b0);
        chk("wrap_addr", bus.flash_addr, 8'h00);
        chk("wrap_data", rd_data,        8'hA7);

        // Reset in the middle of the READ window, away from any clock edge.
        @(negedge sys_clk);
        fdata = 8'h3C;
        k1_n  = 1'b0;
        n = 0;
        while (bus.flash_oe_n !== 1'b0 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        chk("oe_wait_timeout", n < 20, 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_ce_n", bus.flash_ce_n,  1'b1);
        chk("mid_oe_n", bus.flash_oe_n,  1'b1);
        chk("mid_frst", bus.flash_rst_n, 1'b0);
        chk("mid_addr", bus.flash_addr,  8'h00);
        chk("mid_data", rd_data,         8'h00);
        k1_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        do_press(8'h96, 2, 1'b0);
        chk("post_rst_data", rd_data,        8'h96);
        chk("post_rst_addr", bus.flash_addr, 8'h01);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
